// File: rtl/ysyx_23060077_riscv_axi_sram_lat.sv
// AXI-lite SRAM slave with programmable read/write latency, byte strobes and SLVERR decode.
// Read and write channels run as independent single-outstanding FSMs.
module ysyx_23060077_riscv_axi_sram_lat #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           PORT_WIDTH = 3,
  parameter int unsigned           MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned           R_LATENCY  = 1,
  parameter int unsigned           W_LATENCY  = 1
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  output logic                    axi_aw_ready_o,
  input  logic                    axi_aw_valid_i,
  input  logic [PORT_WIDTH-1:0]   axi_aw_port_i,
  input  logic [ADDR_WIDTH-1:0]   axi_aw_addr_i,
  output logic                    axi_w_ready_o,
  input  logic                    axi_w_valid_i,
  input  logic [DATA_WIDTH/8-1:0] axi_w_strb_i,
  input  logic [DATA_WIDTH-1:0]   axi_w_data_i,
  output logic [1:0]              axi_b_resp_o,
  output logic                    axi_b_valid_o,
  input  logic                    axi_b_ready_i,
  output logic                    axi_ar_ready_o,
  input  logic                    axi_ar_valid_i,
  input  logic [PORT_WIDTH-1:0]   axi_ar_port_i,
  input  logic [ADDR_WIDTH-1:0]   axi_ar_addr_i,
  input  logic                    axi_r_ready_i,
  output logic                    axi_r_valid_o,
  output logic [1:0]              axi_r_resp_o,
  output logic [DATA_WIDTH-1:0]   axi_r_data_o
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned Shift = $clog2(StrbW);
  localparam int unsigned IdxW  = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {WIdle, WWait, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RWait, RData} r_state_e;

  w_state_e              w_state_q;
  r_state_e              r_state_q;
  logic                  aw_ready_q, w_ready_q, ar_ready_q;
  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q, r_data_q;
  logic [StrbW-1:0]      w_strb_q;
  logic [3:0]            wcnt_q, rcnt_q;
  logic                  b_valid_q, r_valid_q;
  logic [1:0]            b_resp_q, r_resp_q;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic unused_prot;
  assign unused_prot = ^{axi_aw_port_i, axi_ar_port_i};

  // Address decode on the captured addresses; the subtraction wraps below BASE_ADDR,
  // so the lower-bound test is kept separate from the index bound.
  logic [ADDR_WIDTH-1:0] w_off, r_off;
  logic                  w_ok, r_ok;
  logic [IdxW-1:0]       w_idx, r_idx;

  assign w_off = aw_addr_q - BASE_ADDR;
  assign r_off = ar_addr_q - BASE_ADDR;
  assign w_ok  = (aw_addr_q >= BASE_ADDR) && ((w_off >> Shift) < ADDR_WIDTH'(MEM_DEPTH));
  assign r_ok  = (ar_addr_q >= BASE_ADDR) && ((r_off >> Shift) < ADDR_WIDTH'(MEM_DEPTH));
  assign w_idx = w_off[Shift +: IdxW];
  assign r_idx = r_off[Shift +: IdxW];

  logic aw_hs, w_hs, ar_hs, aw_held_d, w_held_d, w_commit;

  assign aw_hs     = axi_aw_valid_i & aw_ready_q;
  assign w_hs      = axi_w_valid_i & w_ready_q;
  assign ar_hs     = axi_ar_valid_i & ar_ready_q;
  assign aw_held_d = aw_held_q | aw_hs;
  assign w_held_d  = w_held_q | w_hs;
  assign w_commit  = (w_state_q == WWait) && (wcnt_q == '0) && w_ok;

  always_ff @(posedge aclk) begin
    if (w_commit) begin
      for (int i = 0; i < StrbW; i++) begin
        if (w_strb_q[i]) mem_q[w_idx][8*i +: 8] <= w_data_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      w_state_q  <= WIdle;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      wcnt_q     <= '0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= 2'b00;
    end else begin
      unique case (w_state_q)
        WIdle: begin
          if (aw_hs) aw_addr_q <= axi_aw_addr_i;
          if (w_hs) begin
            w_data_q <= axi_w_data_i;
            w_strb_q <= axi_w_strb_i;
          end
          aw_held_q <= aw_held_d;
          w_held_q  <= w_held_d;
          if (aw_held_d && w_held_d) begin
            wcnt_q     <= 4'(W_LATENCY);
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            w_state_q  <= WWait;
          end else begin
            aw_ready_q <= !aw_held_d;
            w_ready_q  <= !w_held_d;
          end
        end
        WWait: begin
          if (wcnt_q == '0) begin
            b_valid_q <= 1'b1;
            b_resp_q  <= w_ok ? 2'b00 : 2'b10;
            w_state_q <= WResp;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        WResp: begin
          if (axi_b_ready_i) begin
            b_valid_q  <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b1;
            w_state_q  <= WIdle;
          end
        end
        default: w_state_q <= WIdle;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state_q  <= RIdle;
      ar_ready_q <= 1'b0;
      ar_addr_q  <= '0;
      rcnt_q     <= '0;
      r_valid_q  <= 1'b0;
      r_resp_q   <= 2'b00;
      r_data_q   <= '0;
    end else begin
      unique case (r_state_q)
        RIdle: begin
          if (ar_hs) begin
            ar_addr_q  <= axi_ar_addr_i;
            rcnt_q     <= 4'(R_LATENCY);
            ar_ready_q <= 1'b0;
            r_state_q  <= RWait;
          end else begin
            ar_ready_q <= 1'b1;
          end
        end
        RWait: begin
          if (rcnt_q == '0) begin
            // Same-edge write commit is not visible here: the array updates after this sample.
            r_data_q  <= r_ok ? mem_q[r_idx] : '0;
            r_resp_q  <= r_ok ? 2'b00 : 2'b10;
            r_valid_q <= 1'b1;
            r_state_q <= RData;
          end else begin
            rcnt_q <= rcnt_q - 4'd1;
          end
        end
        RData: begin
          if (axi_r_ready_i) begin
            r_valid_q  <= 1'b0;
            ar_ready_q <= 1'b1;
            r_state_q  <= RIdle;
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

  assign axi_aw_ready_o = aw_ready_q;
  assign axi_w_ready_o  = w_ready_q;
  assign axi_b_valid_o  = b_valid_q;
  assign axi_b_resp_o   = b_resp_q;
  assign axi_ar_ready_o = ar_ready_q;
  assign axi_r_valid_o  = r_valid_q;
  assign axi_r_resp_o   = r_resp_q;
  assign axi_r_data_o   = r_data_q;

endmodule

// File: tb/tb_ysyx_23060077_riscv_axi_sram_lat.sv
// Scoreboard bench: drivers push expected B/R responses, monitors pop and compare on handshakes.
module tb_ysyx_23060077_riscv_axi_sram_lat;

  localparam int RL = 3;
  localparam int WL = 4;

  logic        aclk, areset_n;
  logic        axi_aw_ready_o, axi_aw_valid_i;
  logic [2:0]  axi_aw_port_i, axi_ar_port_i;
  logic [31:0] axi_aw_addr_i, axi_ar_addr_i;
  logic        axi_w_ready_o, axi_w_valid_i;
  logic [3:0]  axi_w_strb_i;
  logic [31:0] axi_w_data_i;
  logic [1:0]  axi_b_resp_o, axi_r_resp_o;
  logic        axi_b_valid_o, axi_b_ready_i;
  logic        axi_ar_ready_o, axi_ar_valid_i;
  logic        axi_r_ready_i, axi_r_valid_o;
  logic [31:0] axi_r_data_o;

  ysyx_23060077_riscv_axi_sram_lat #(
    .R_LATENCY(RL),
    .W_LATENCY(WL)
  ) dut (
    .aclk           (aclk),
    .areset_n       (areset_n),
    .axi_aw_ready_o (axi_aw_ready_o),
    .axi_aw_valid_i (axi_aw_valid_i),
    .axi_aw_port_i  (axi_aw_port_i),
    .axi_aw_addr_i  (axi_aw_addr_i),
    .axi_w_ready_o  (axi_w_ready_o),
    .axi_w_valid_i  (axi_w_valid_i),
    .axi_w_strb_i   (axi_w_strb_i),
    .axi_w_data_i   (axi_w_data_i),
    .axi_b_resp_o   (axi_b_resp_o),
    .axi_b_valid_o  (axi_b_valid_o),
    .axi_b_ready_i  (axi_b_ready_i),
    .axi_ar_ready_o (axi_ar_ready_o),
    .axi_ar_valid_i (axi_ar_valid_i),
    .axi_ar_port_i  (axi_ar_port_i),
    .axi_ar_addr_i  (axi_ar_addr_i),
    .axi_r_ready_i  (axi_r_ready_i),
    .axi_r_valid_o  (axi_r_valid_o),
    .axi_r_resp_o   (axi_r_resp_o),
    .axi_r_data_o   (axi_r_data_o)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          rise;
  } exp_t;

  exp_t rq[$];
  exp_t bq[$];
  int   cyc;
  int   n_chk;
  int   n_pass;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  // ch: 0 = AW only, 1 = W only, 2 = both together. Returns the handshake edge or -1.
  task automatic hs_chan(input int ch, output int hs);
    if (ch != 1) axi_aw_valid_i = 1'b1;
    if (ch != 0) axi_w_valid_i = 1'b1;
    hs = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if ((ch == 1 || axi_aw_ready_o) && (ch == 0 || axi_w_ready_o)) begin
        hs = cyc + 1;
        break;
      end
    end
    @(posedge aclk);
    #1;
    axi_aw_valid_i = 1'b0;
    axi_w_valid_i  = 1'b0;
  endtask

  // mode: 0 = AW and W together, 1 = W first, 2 = AW first; gap = edges between handshakes.
  task automatic do_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                       input int mode, input int gap, input logic [1:0] resp, input bit push);
    int   h1, hs;
    exp_t e;
    axi_aw_addr_i = addr;
    axi_w_data_i  = data;
    axi_w_strb_i  = strb;
    if (mode == 0) begin
      hs_chan(2, hs);
    end else begin
      hs_chan((mode == 1) ? 1 : 0, h1);
      repeat (gap - 1) @(posedge aclk);
      #1;
      hs_chan((mode == 1) ? 0 : 1, hs);
      if (h1 < 0) hs = -1;
    end
    if (hs < 0) chk("aw_w_handshake_timeout", 32'd0, 32'd1);
    else if (push) begin
      e.data = 32'd0;
      e.resp = resp;
      e.rise = hs + 1 + WL;
      bq.push_back(e);
    end
  endtask

  task automatic do_ar(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    int   hs;
    exp_t e;
    axi_ar_addr_i  = addr;
    axi_ar_valid_i = 1'b1;
    hs = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (axi_ar_ready_o) begin
        hs = cyc + 1;
        break;
      end
    end
    @(posedge aclk);
    #1;
    axi_ar_valid_i = 1'b0;
    if (hs < 0) chk("ar_handshake_timeout", 32'd0, 32'd1);
    else begin
      e.data = data;
      e.resp = resp;
      e.rise = hs + 1 + RL;
      rq.push_back(e);
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (rq.size() == 0 && bq.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("response_timeout", 32'd0, 32'd1);
    @(posedge aclk);
    #1;
  endtask

  // Read-channel monitor
  initial begin
    bit rv_prev, r_pend;
    rv_prev = 1'b0;
    r_pend  = 1'b0;
    forever begin
      @(negedge aclk);
      if (!areset_n) begin
        rv_prev = 1'b0;
        r_pend  = 1'b0;
      end else begin
        if (r_pend) begin
          chk("ar_ready_after_r_hs", {31'd0, axi_ar_ready_o}, 32'd1);
          chk("r_valid_after_r_hs", {31'd0, axi_r_valid_o}, 32'd0);
          r_pend = 1'b0;
        end
        if (axi_r_valid_o) begin
          chk("ar_ready_busy", {31'd0, axi_ar_ready_o}, 32'd0);
          if (rq.size() == 0) begin
            if (!rv_prev) chk("r_valid_unexpected", 32'd1, 32'd0);
          end else begin
            if (!rv_prev) chk("r_valid_rise_edge", cyc, rq[0].rise);
            chk("r_data", axi_r_data_o, rq[0].data);
            chk("r_resp", {30'd0, axi_r_resp_o}, {30'd0, rq[0].resp});
            if (axi_r_ready_i) begin
              void'(rq.pop_front());
              r_pend = 1'b1;
            end
          end
        end
        rv_prev = axi_r_valid_o;
      end
    end
  end

  // Write-response monitor
  initial begin
    bit bv_prev, b_pend;
    bv_prev = 1'b0;
    b_pend  = 1'b0;
    forever begin
      @(negedge aclk);
      if (!areset_n) begin
        bv_prev = 1'b0;
        b_pend  = 1'b0;
      end else begin
        if (b_pend) begin
          chk("aw_w_ready_after_b_hs", {30'd0, axi_aw_ready_o, axi_w_ready_o}, 32'd3);
          chk("b_valid_after_b_hs", {31'd0, axi_b_valid_o}, 32'd0);
          b_pend = 1'b0;
        end
        if (axi_b_valid_o) begin
          chk("aw_w_ready_busy", {30'd0, axi_aw_ready_o, axi_w_ready_o}, 32'd0);
          if (bq.size() == 0) begin
            if (!bv_prev) chk("b_valid_unexpected", 32'd1, 32'd0);
          end else begin
            if (!bv_prev) chk("b_valid_rise_edge", cyc, bq[0].rise);
            chk("b_resp", {30'd0, axi_b_resp_o}, {30'd0, bq[0].resp});
            if (axi_b_ready_i) begin
              void'(bq.pop_front());
              b_pend = 1'b1;
            end
          end
        end
        bv_prev = axi_b_valid_o;
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_readies"}, {29'd0, axi_aw_ready_o, axi_w_ready_o, axi_ar_ready_o}, 32'd0);
    chk({tag, "_valids"}, {30'd0, axi_b_valid_o, axi_r_valid_o}, 32'd0);
    chk({tag, "_resps"}, {28'd0, axi_b_resp_o, axi_r_resp_o}, 32'd0);
    chk({tag, "_r_data"}, axi_r_data_o, 32'd0);
  endtask

  initial begin
    n_chk          = 0;
    n_pass         = 0;
    axi_aw_valid_i = 1'b0;
    axi_w_valid_i  = 1'b0;
    axi_ar_valid_i = 1'b0;
    axi_aw_port_i  = 3'd0;
    axi_ar_port_i  = 3'd0;
    axi_aw_addr_i  = 32'd0;
    axi_ar_addr_i  = 32'd0;
    axi_w_data_i   = 32'd0;
    axi_w_strb_i   = 4'd0;
    axi_b_ready_i  = 1'b1;
    axi_r_ready_i  = 1'b1;
    areset_n       = 1'b1;
    #1 areset_n = 1'b0;
    #1 chk_all_zero("reset");

    repeat (2) @(posedge aclk);
    #1 areset_n = 1'b1;
    @(negedge aclk);
    chk("readies_before_first_edge", {29'd0, axi_aw_ready_o, axi_w_ready_o, axi_ar_ready_o}, 32'd0);
    @(negedge aclk);
    chk("readies_after_release", {29'd0, axi_aw_ready_o, axi_w_ready_o, axi_ar_ready_o}, 32'd7);
    chk("valids_after_release", {30'd0, axi_b_valid_o, axi_r_valid_o}, 32'd0);
    @(posedge aclk);
    #1;

    // Seed first and last words, then the main target word (W leads AW by 2 edges)
    do_wr(32'h8000_0000, 32'hCAFE_F00D, 4'hF, 0, 0, 2'b00, 1'b1);
    wait_idle();
    do_wr(32'h8000_0FFC, 32'h0BAD_C0DE, 4'hF, 2, 1, 2'b00, 1'b1);
    wait_idle();
    do_wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1, 2, 2'b00, 1'b1);
    wait_idle();
    do_ar(32'h8000_0010, 32'hDEAD_BEEF, 2'b00);
    wait_idle();

    do_wr(32'h8000_0010, 32'h0000_AB00, 4'b0010, 2, 3, 2'b00, 1'b1);
    wait_idle();
    do_ar(32'h8000_0010, 32'hDEAD_ABEF, 2'b00);
    wait_idle();

    // Out-of-range: below base and one word past the end
    do_ar(32'h7FFF_FFFC, 32'h0000_0000, 2'b10);
    wait_idle();
    do_ar(32'h8000_1000, 32'h0000_0000, 2'b10);
    wait_idle();
    do_wr(32'h7FFF_FFFC, 32'h5555_5555, 4'hF, 0, 0, 2'b10, 1'b1);
    wait_idle();
    do_wr(32'h8000_1000, 32'hAAAA_AAAA, 4'hF, 1, 1, 2'b10, 1'b1);
    wait_idle();
    do_ar(32'h8000_0000, 32'hCAFE_F00D, 2'b00);
    wait_idle();
    do_ar(32'h8000_0FFC, 32'h0BAD_C0DE, 2'b00);
    wait_idle();

    // Misaligned read with R backpressure for 5 cycles after r_valid
    axi_r_ready_i = 1'b0;
    do_ar(32'h8000_0013, 32'hDEAD_ABEF, 2'b00);
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (axi_r_valid_o) break;
    end
    repeat (5) @(negedge aclk);
    @(posedge aclk);
    #1 axi_r_ready_i = 1'b1;
    wait_idle();

    // Reset during the write wait phase must abort the commit
    do_wr(32'h8000_0010, 32'h1111_1111, 4'hF, 0, 0, 2'b00, 1'b0);
    @(posedge aclk);
    @(posedge aclk);
    #2 areset_n = 1'b0;
    #1 chk_all_zero("mid_write_reset");
    repeat (2) @(posedge aclk);
    #1 areset_n = 1'b1;
    @(posedge aclk);
    #1;
    do_ar(32'h8000_0010, 32'hDEAD_ABEF, 2'b00);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
